// File: rtl/fabric_tag_merge.sv
// fabric_tag_merge: round-robin merge of NUM_INPUTS untagged streams into one
// registered tagged stream. Output payload is {tag, data}, the layout the
// temporal switch consumes. A sticky error latch reports duplicate enabled
// tags and traffic on disabled channels.
module fabric_tag_merge #(
  parameter  int NUM_INPUTS    = 4,
  parameter  int DATA_WIDTH    = 32,
  parameter  int TAG_WIDTH     = 4,
  localparam int PAYLOAD_WIDTH = DATA_WIDTH + TAG_WIDTH,
  localparam int RR_PTR_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_INPUTS-1:0]              in_valid,
  output logic [NUM_INPUTS-1:0]              in_ready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0]   in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [PAYLOAD_WIDTH-1:0]           out_data,
  input  logic [NUM_INPUTS*(1+TAG_WIDTH)-1:0] cfg_data,
  output logic                               error_valid,
  output logic [15:0]                        error_code
);

  // Error codes shared with the rest of the fabric; lower value = higher priority.
  localparam logic [15:0] CFG_TAG_MERGE_DUP_TAG       = 16'h0008;
  localparam logic [15:0] RT_TAG_MERGE_DISABLED_INPUT = 16'h0108;

  if (NUM_INPUTS < 1) begin : g_bad_cfg
    $fatal(1, "fabric_tag_merge: NUM_INPUTS must be >= 1");
  end

  logic [NUM_INPUTS-1:0]                en;
  logic [NUM_INPUTS-1:0][TAG_WIDTH-1:0] tag;
  logic [NUM_INPUTS-1:0]                elig;

  // Unpack the per-channel {enable, tag} configuration entries.
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_cfg
    assign en[i]  = cfg_data[i*(1+TAG_WIDTH) + TAG_WIDTH];
    assign tag[i] = cfg_data[i*(1+TAG_WIDTH) +: TAG_WIDTH];
  end

  assign elig = in_valid & en;

  logic [RR_PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                     out_valid_q, out_valid_d;
  logic [PAYLOAD_WIDTH-1:0] out_data_q, out_data_d;
  logic                     err_valid_q, err_valid_d;
  logic [15:0]              err_code_q, err_code_d;

  logic                     arb_valid;
  logic [RR_PTR_W-1:0]      winner;
  logic [DATA_WIDTH-1:0]    win_data;
  logic [TAG_WIDTH-1:0]     win_tag;
  logic                     load;

  // Round-robin scan from rr_ptr; walking offsets high to low lets the
  // closest eligible channel overwrite the farther ones, so no early exit.
  always_comb begin
    int idx;
    arb_valid = 1'b0;
    winner    = '0;
    win_data  = '0;
    win_tag   = '0;
    idx       = 0;
    for (int k = NUM_INPUTS-1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % NUM_INPUTS;
      if (elig[idx]) begin
        arb_valid = 1'b1;
        winner    = RR_PTR_W'(idx);
        win_data  = in_data[idx*DATA_WIDTH +: DATA_WIDTH];
        win_tag   = tag[idx];
      end
    end
  end

  // A new beat may enter when the output slot is empty or draining this cycle.
  assign load = rst_n && arb_valid && (!out_valid_q || out_ready);

  // Grant is one-hot on the winner, only when the beat is actually taken.
  always_comb begin
    in_ready = '0;
    if (load) in_ready[winner] = 1'b1;
  end

  // Error detection; a duplicate tag outranks a disabled-input error.
  always_comb begin
    logic dup, dis;
    dup = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++)
      for (int j = i + 1; j < NUM_INPUTS; j++)
        if (en[i] && en[j] && (tag[i] == tag[j])) dup = 1'b1;
    dis         = |(in_valid & ~en);
    err_valid_d = err_valid_q;
    err_code_d  = err_code_q;
    if ((dup || dis) && !err_valid_q) begin
      err_valid_d = 1'b1;
      err_code_d  = dup ? CFG_TAG_MERGE_DUP_TAG : RT_TAG_MERGE_DISABLED_INPUT;
    end
  end

  // Output slot and pointer next state: load, drain, or hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = {win_tag, win_data};
      rr_ptr_d    = (winner == RR_PTR_W'(NUM_INPUTS-1)) ? '0 : winner + 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      rr_ptr_q    <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rr_ptr_q    <= rr_ptr_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign error_valid = err_valid_q;
  assign error_code  = err_code_q;

endmodule

// File: tb/tb_fabric_tag_merge.sv
// Directed bench for fabric_tag_merge: stimulus pushes expected output beats
// into a queue, a negedge monitor pops and compares on every output handshake.
module tb_fabric_tag_merge;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam logic [15:0] DUP = 16'h0008;
  localparam logic [15:0] DIS = 16'h0108;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      in_valid;
  logic [N-1:0]      in_ready;
  logic [N*DW-1:0]   in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DW+TW-1:0]  out_data;
  logic [N*(1+TW)-1:0] cfg_data;
  logic              error_valid;
  logic [15:0]       error_code;

  fabric_tag_merge #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .cfg_data(cfg_data), .error_valid(error_valid),
    .error_code(error_code));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;
  logic [DW+TW-1:0] exp_q[$];

  localparam logic [N*DW-1:0] DATA_DEF = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N*(1+TW)-1:0] mk_cfg(input logic [3:0] en,
      input logic [3:0] t0, input logic [3:0] t1, input logic [3:0] t2, input logic [3:0] t3);
    return {en[3], t3, en[2], t2, en[1], t1, en[0], t0};
  endfunction

  task automatic tick; @(posedge clk); #1; endtask
  task automatic neg;  @(negedge clk);     endtask

  // Monitor: every accepted output beat must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_beat", {28'd0, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("out_beat", {28'd0, out_data}, {28'd0, exp_q.pop_front()});
    end
  end

  localparam logic [15:0] NORM_EN = 4'b1111;
  logic [3:0] fair_rdy [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [35:0] fair_exp [6] = '{36'h3_11111111, 36'h5_22222222, 36'h9_33333333,
                                36'hC_44444444, 36'h3_11111111, 36'h5_22222222};

  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    in_data   = DATA_DEF;
    cfg_data  = mk_cfg(4'b1111, 4'd3, 4'd5, 4'd9, 4'd12);
    tick; tick;
    // Reset state
    neg;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", {28'd0, out_data}, 64'd0);
    chk("rst_err_valid", {63'd0, error_valid}, 64'd0);
    chk("rst_err_code", {48'd0, error_code}, 64'd0);
    chk("rst_in_ready", {60'd0, in_ready}, 64'd0);
    in_valid = 4'h0;
    tick;
    rst_n = 1'b1;
    tick;

    // Single beat from ch1
    in_data[1*DW +: DW] = 32'hDEADBEEF;
    in_valid = 4'b0010;
    exp_q.push_back(36'h5_DEADBEEF);
    neg; chk("single_in_ready", {60'd0, in_ready}, 64'b0010);
    tick;
    in_valid = 4'b0000;
    in_data  = DATA_DEF;
    neg; chk("single_out_valid", {63'd0, out_valid}, 64'd1);
    tick;
    // Pointer now at 2: with all valid, ch2 must win
    in_valid = 4'b1111;
    exp_q.push_back(36'h9_33333333);
    neg; chk("ptr_after_single", {60'd0, in_ready}, 64'b0100);
    tick;
    in_valid = 4'b0000;
    tick;

    // Fairness from reset
    rst_n = 1'b0; tick; rst_n = 1'b1;
    in_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(fair_exp[i]);
      neg; chk("fair_grant", {60'd0, in_ready}, {60'd0, fair_rdy[i]});
      tick;
    end
    in_valid = 4'b0000;
    tick;

    // Backpressure
    rst_n = 1'b0; tick; rst_n = 1'b1;
    in_valid = 4'b0001;
    exp_q.push_back(36'h3_11111111);
    neg; chk("bp_load", {60'd0, in_ready}, 64'b0001);
    tick;
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      neg;
      chk("bp_in_ready", {60'd0, in_ready}, 64'd0);
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_out_data", {28'd0, out_data}, 64'h3_11111111);
      tick;
    end
    out_ready = 1'b1;
    exp_q.push_back(36'h5_22222222);
    neg; chk("bp_release_grant", {60'd0, in_ready}, 64'b0010);
    tick;
    in_valid = 4'b0000;
    tick;

    // Disabled channel 2 (pointer is 2 here)
    cfg_data = mk_cfg(4'b1011, 4'd3, 4'd5, 4'd9, 4'd12);
    in_valid = 4'b0100;
    neg;
    chk("dis_in_ready", {60'd0, in_ready}, 64'd0);
    chk("dis_err_pre", {63'd0, error_valid}, 64'd0);
    tick;
    neg;
    chk("dis_err_valid", {63'd0, error_valid}, 64'd1);
    chk("dis_err_code", {48'd0, error_code}, {48'd0, DIS});
    tick;
    in_valid = 4'b0101;
    exp_q.push_back(36'h3_11111111);
    neg; chk("dis_ch0_pass", {60'd0, in_ready}, 64'b0001);
    tick;
    in_valid = 4'b0100;
    neg; chk("dis_still_stalled", {60'd0, in_ready}, 64'd0);
    tick;
    in_valid = 4'b0000;
    tick;

    // Duplicate tag, then a later disabled-input error must not overwrite
    cfg_data = mk_cfg(4'b1111, 4'd7, 4'd5, 4'd9, 4'd7);
    rst_n = 1'b0; tick; rst_n = 1'b1;
    neg; chk("dup_err_cleared", {63'd0, error_valid}, 64'd0);
    tick;
    neg;
    chk("dup_err_valid", {63'd0, error_valid}, 64'd1);
    chk("dup_err_code", {48'd0, error_code}, {48'd0, DUP});
    tick;
    cfg_data = mk_cfg(4'b1011, 4'd7, 4'd5, 4'd9, 4'd7);
    in_valid = 4'b0101;
    exp_q.push_back(36'h7_11111111);
    neg; chk("dup_ch0_pass", {60'd0, in_ready}, 64'b0001);
    tick;
    in_valid = 4'b0000;
    neg; chk("dup_code_sticky", {48'd0, error_code}, {48'd0, DUP});
    tick;

    // Reset mid-stream with a pending beat and a latched error
    cfg_data  = mk_cfg(4'b1011, 4'd3, 4'd5, 4'd9, 4'd12);
    rst_n = 1'b0; tick; rst_n = 1'b1;
    in_valid  = 4'b1100;
    out_ready = 1'b0;
    tick;
    in_valid = 4'b0000;
    neg;
    chk("mid_out_valid_pre", {63'd0, out_valid}, 64'd1);
    chk("mid_err_pre", {63'd0, error_valid}, 64'd1);
    tick;
    rst_n = 1'b0; tick; rst_n = 1'b1;
    cfg_data = mk_cfg(4'b1111, 4'd3, 4'd5, 4'd9, 4'd12);
    neg;
    chk("mid_out_valid_post", {63'd0, out_valid}, 64'd0);
    chk("mid_err_post", {63'd0, error_valid}, 64'd0);
    tick;
    out_ready = 1'b1;
    in_valid  = 4'b1111;
    exp_q.push_back(36'h3_11111111);
    neg; chk("mid_first_grant", {60'd0, in_ready}, 64'b0001);
    tick;
    in_valid = 4'b0000;
    tick; tick;

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule

// File: doc/fabric_tag_merge.md
Name: fabric_tag_merge

Overview:
- Producer side of the tagged-stream interface: merges NUM_INPUTS untagged streaming inputs into one tagged output stream.
- Each input channel has a configured tag. The block arbitrates round-robin among the inputs, prepends the winner's tag to its data, and registers the result.
- Output payload layout matches what fabric_temporal_sw consumes: data in [DATA_WIDTH-1:0], tag in [DATA_WIDTH +: TAG_WIDTH].
- Used at fabric edges and PE outputs that feed temporal switches.

Parameters:
- NUM_INPUTS, 4, number of untagged input channels (>=1; $fatal otherwise)
- DATA_WIDTH, 32, data width per channel (>=1)
- TAG_WIDTH, 4, tag width (>=1)
- PAYLOAD_WIDTH, localparam DATA_WIDTH+TAG_WIDTH, output payload width
- RR_PTR_W, localparam (NUM_INPUTS>1) ? $clog2(NUM_INPUTS) : 1, arbitration pointer width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  NUM_INPUTS  per-channel valid; bit i = channel i
- in_ready  out  NUM_INPUTS  per-channel ready
- in_data  in  NUM_INPUTS*DATA_WIDTH  packed data; channel i at [i*DATA_WIDTH +: DATA_WIDTH]
- out_valid  out  1  tagged output valid
- out_ready  in  1  downstream ready
- out_data  out  PAYLOAD_WIDTH  {tag, data}
- cfg_data  in  NUM_INPUTS*(1+TAG_WIDTH)  per-channel entry {enable(1), tag(TAG_WIDTH)}; entry i at [i*(1+TAG_WIDTH) +: 1+TAG_WIDTH], tag in the LSBs
- error_valid  out  1  sticky error flag
- error_code  out  16  first captured error code

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low: rst_n is sampled only on posedge clk.
- Reset values: out_valid=0, out_data=0, rr_ptr=0, error_valid=0, error_code=0. in_ready is combinational and is 0 while rst_n=0.
- Eligibility: channel i is eligible when in_valid[i] && enable[i].
- Arbitration (combinational):
  - Scan channels rr_ptr, rr_ptr+1, ... mod NUM_INPUTS.
  - The first eligible channel is the winner; arb_valid=1 if any channel is eligible.
- Load condition: load = arb_valid && (!out_valid || out_ready).
  - in_ready[i] = load && winner==i. At most one in_ready bit is high in any cycle.
- Output register:
  - On load: out_valid<=1, out_data<={tag[winner], in_data[winner]}, rr_ptr<=(winner+1) mod NUM_INPUTS.
  - Else if out_ready: out_valid<=0, out_data holds its value.
  - Else: hold.
- Latency and throughput: one cycle from input handshake to out_valid. Back-to-back operation gives one beat per cycle when out_ready stays high; the same-cycle drain+load is handled by the load condition.
- Backpressure: while out_valid && !out_ready, all in_ready=0. out_data and out_valid must stay stable until the handshake.
- rr_ptr advances only on an input handshake, never on stall or idle. When NUM_INPUTS=1, rr_ptr stays 0.
- Disabled channel: in_valid[i] && !enable[i] gives in_ready[i]=0 permanently (the channel stalls) and raises the runtime error below.
- Errors (codes defined in fabric_common.svh), checked every cycle; if several are present, the lowest code wins:
  - CFG_TAG_MERGE_DUP_TAG: two enabled entries have equal tags.
  - RT_TAG_MERGE_DISABLED_INPUT: valid on a disabled channel.
- Error latch: on the first cycle with err_detect && !error_valid, set error_valid<=1 and capture error_code. Both hold until reset.
- Errors do not block data flow on enabled channels.
- Reset mid-operation: a pending output beat is discarded (out_valid=0 on the next cycle), rr_ptr returns to 0, and the error latch clears.
- cfg_data must be held stable while traffic flows; a change takes effect on the next arbitration.

Test Plan:
- Single beat (NUM_INPUTS=4, DATA_WIDTH=32, TAG_WIDTH=4; cfg: ch0 tag 3, ch1 tag 5, ch2 tag 9, ch3 tag 12, all enabled):
  - Stimulus: ch1 valid with data 0xDEADBEEF, out_ready=1.
  - Required: in_ready[1]=1 that cycle; the next cycle out_valid=1 and out_data=0x5_DEADBEEF; rr_ptr=2.
- Fairness: all four channels valid continuously, out_ready=1 → grant order 0,1,2,3,0,1; the output tags sequence 3,5,9,12,3,5, one beat per cycle.
- Backpressure: load a beat from ch0, then hold out_ready=0 for 3 cycles with all channels valid → out_data stable, all in_ready=0, rr_ptr unchanged. Release out_ready → ch1 is granted in the same cycle the held beat drains.
- Disabled channel: enable[2]=0, ch2 valid → in_ready[2]=0 forever; one cycle later error_valid=1 with error_code=RT_TAG_MERGE_DISABLED_INPUT; ch0 traffic still passes.
- Duplicate tag: set ch0 and ch3 both enabled with tag 7 → error_valid=1 next cycle, error_code=CFG_TAG_MERGE_DUP_TAG. Adding a disabled-input error later leaves the code unchanged (sticky).
- Reset mid-stream: assert rst_n=0 for one cycle while out_valid=1 and out_ready=0 → next cycle out_valid=0, error_valid=0, and the first grant after reset goes to ch0.
